// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: one multiply-by-10 accumulate per digit per clock,
// most significant digit first; invalid digits force bin=0 with err=1.
module bcd2bin #(
  parameter int NDIG = 8,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4*NDIG-1:0] bcd,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [W-1:0]    bin
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_next;
  logic [4*NDIG-1:0]   shreg;
  logic [W-1:0]        acc, acc_next;
  logic                err_flag, err_next;
  logic [CW-1:0]       cnt;
  logic [3:0]          digit;
  logic                load, last;

  // acc*10 built from two shifts so no wide multiplier is needed
  assign digit    = shreg[4*NDIG-1 -: 4];
  assign acc_next = (acc << 3) + (acc << 1) + W'(digit);
  assign err_next = err_flag | (digit > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt == '0) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      acc      <= '0;
      err_flag <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bin      <= '0;
    end else if (load) begin
      shreg    <= bcd;
      acc      <= '0;
      err_flag <= 1'b0;
      cnt      <= CW'(NDIG - 1);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (state == CONV) begin
      acc      <= acc_next;
      shreg    <= shreg << 4;
      err_flag <= err_next;
      cnt      <= cnt - 1'b1;
      // A bad digit must never leak a partial value onto bin
      if (last) begin
        bin  <= err_next ? '0 : acc_next;
        err  <= err_next;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule
